// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences one MULT or DIV operation through an external iterative
// multiplier/divider and owns the architectural HI/LO registers.
//
// Ports:
//   clock, reset            single clock; synchronous active-high reset
//   OpStart, OpSel          one-cycle request (0 = MULT, 1 = DIV), sampled only in IDLE
//   DivisorIn               divisor operand, checked for zero at request time
//   MultDone, DivDone       unit completion flags
//   MultHIIn/MultLOIn       multiplier result (signed 64-bit product)
//   DivHIIn/DivLOIn         divider result (remainder / quotient)
//   MultCtrl, DivCtrl       level enables, high through ISSUE and WAIT of the selected unit
//   HIOut, LOOut            architectural HI/LO
//   Busy                    high outside IDLE
//   OpDone                  one-cycle pulse after HI/LO update
//   DivZero                 one-cycle pulse on a DIV request with a zero divisor
//   Timeout                 one-cycle pulse on watchdog abort
//
// Optional feature: define MULDIV_TIMEOUT_EN to enable the WAIT-state watchdog, which aborts
// after TIMEOUT_CYCLES WAIT cycles without Done. Without it Timeout is tied low.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        OpStart,
  input  logic        OpSel,
  input  logic [31:0] DivisorIn,
  input  logic        MultDone,
  input  logic        DivDone,
  input  logic [31:0] MultHIIn,
  input  logic [31:0] MultLOIn,
  input  logic [31:0] DivHIIn,
  input  logic [31:0] DivLOIn,
  output logic        MultCtrl,
  output logic        DivCtrl,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut,
  output logic        Busy,
  output logic        OpDone,
  output logic        DivZero,
  output logic        Timeout
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        op_sel_q, op_sel_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;
  logic        sel_done;
  logic        wait_abort;

  // Done of the unit that owns the current operation.
  assign sel_done = op_sel_q ? DivDone : MultDone;

  always_comb begin
    state_d    = state_q;
    op_sel_d   = op_sel_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (OpStart) begin
          if (OpSel && (DivisorIn == 32'd0)) begin
            div_zero_d = 1'b1;
          end else begin
            op_sel_d = OpSel;
            state_d  = StIssue;
          end
        end
      end
      // Done is deliberately ignored here: units present a stale Done until re-initialised.
      StIssue: state_d = StWait;
      StWait: begin
        if (sel_done) begin
          if (op_sel_q) begin
            hi_d = DivHIIn;
            lo_d = DivLOIn;
          end else begin
            hi_d = MultHIIn;
            lo_d = MultLOIn;
          end
          state_d = StDone;
        end else if (wait_abort) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_sel_q   <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_sel_q   <= op_sel_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q;

  // Counter holds the number of completed WAIT cycles; abort in the last allowed one.
  assign wait_abort = (state_q == StWait) && !sel_done &&
                      (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == StIssue) begin
      wd_cnt_d = '0;
    end else if (state_q == StWait) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wait_abort;
    end
  end

  assign Timeout = timeout_q;
`else
  assign wait_abort = 1'b0;
  assign Timeout    = 1'b0;
`endif

  // Ctrl is a pure state decode, so leaving ISSUE/WAIT (DONE, abort, reset) drops it at once.
  assign MultCtrl = ((state_q == StIssue) || (state_q == StWait)) && !op_sel_q;
  assign DivCtrl  = ((state_q == StIssue) || (state_q == StWait)) && op_sel_q;
  assign Busy     = (state_q != StIdle);
  assign OpDone   = (state_q == StDone);
  assign DivZero  = div_zero_q;
  assign HIOut    = hi_q;
  assign LOOut    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with behavioural iterative multiplier/divider
// stubs. Expected HI/LO values are queued when an operation is requested and popped when
// OpDone is observed.
module tb_muldiv_sequencer;

`ifdef MULDIV_TIMEOUT_EN
  localparam int TimeoutCycles = 8;
  localparam int RstWait       = 5;
`else
  localparam int TimeoutCycles = 64;
  localparam int RstWait       = 10;
`endif

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        OpStart   = 1'b0;
  logic        OpSel     = 1'b0;
  logic [31:0] DivisorIn = 32'd0;
  logic        MultDone  = 1'b0;
  logic        DivDone   = 1'b0;
  logic [31:0] MultHIIn  = 32'd0;
  logic [31:0] MultLOIn  = 32'd0;
  logic [31:0] DivHIIn   = 32'd0;
  logic [31:0] DivLOIn   = 32'd0;
  logic        MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout;
  logic [31:0] HIOut, LOOut;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 5;
  bit          stub   = 1'b0;
  logic [31:0] op_a   = 32'd0;
  logic [31:0] op_b   = 32'd1;
  int          mcnt   = 0;
  int          dcnt   = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .OpStart  (OpStart),
    .OpSel    (OpSel),
    .DivisorIn(DivisorIn),
    .MultDone (MultDone),
    .DivDone  (DivDone),
    .MultHIIn (MultHIIn),
    .MultLOIn (MultLOIn),
    .DivHIIn  (DivHIIn),
    .DivLOIn  (DivLOIn),
    .MultCtrl (MultCtrl),
    .DivCtrl  (DivCtrl),
    .HIOut    (HIOut),
    .LOOut    (LOOut),
    .Busy     (Busy),
    .OpDone   (OpDone),
    .DivZero  (DivZero),
    .Timeout  (Timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // Unit stubs: Done clears on the first enabled edge, rises after 'lat' cycles, and is
  // held (stale) after Ctrl drops until the next operation starts.
  always @(posedge clock) begin
    if (!MultCtrl) begin
      mcnt <= 0;
    end else if (mcnt == 0) begin
      MultDone <= 1'b0;
      mcnt     <= 1;
    end else if (mcnt == lat && !stub) begin
      MultDone             <= 1'b1;
      {MultHIIn, MultLOIn} <= ref_mul(op_a, op_b);
      mcnt                 <= lat + 1;
    end else if (mcnt < lat) begin
      mcnt <= mcnt + 1;
    end
  end

  always @(posedge clock) begin
    if (!DivCtrl) begin
      dcnt <= 0;
    end else if (dcnt == 0) begin
      DivDone <= 1'b0;
      dcnt    <= 1;
    end else if (dcnt == lat && !stub) begin
      DivDone            <= 1'b1;
      {DivHIIn, DivLOIn} <= ref_div(op_a, op_b);
      dcnt               <= lat + 1;
    end else if (dcnt < lat) begin
      dcnt <= dcnt + 1;
    end
  end

  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input bit poke, input string name);
    logic [63:0] want;
    bit          seen;
    logic        sc, oc;
    @(negedge clock);
    checks++;
    if (Busy !== 1'b0 || OpDone !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before: Busy=%b OpDone=%b want 0/0", name, Busy, OpDone);
    end
    op_a = a;
    op_b = b;
    exp_q.push_back(expv);
    OpStart   = 1'b1;
    OpSel     = sel;
    DivisorIn = b;
    @(negedge clock);
    OpStart = 1'b0;
    sc = sel ? DivCtrl : MultCtrl;
    oc = sel ? MultCtrl : DivCtrl;
    checks++;
    if (Busy !== 1'b1 || sc !== 1'b1 || oc !== 1'b0) begin
      errors++;
      $display("FAIL %s issue: Busy=%b selCtrl=%b otherCtrl=%b want 1/1/0", name, Busy, sc, oc);
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (poke && i == 1) begin
        OpStart = 1'b1;
        OpSel   = ~sel;
      end else begin
        OpStart = 1'b0;
      end
      sc = sel ? DivCtrl : MultCtrl;
      oc = sel ? MultCtrl : DivCtrl;
      if (OpDone === 1'b1) begin
        seen = 1'b1;
        want = exp_q.pop_front();
        checks++;
        if (MultCtrl !== 1'b0 || DivCtrl !== 1'b0) begin
          errors++;
          $display("FAIL %s done_ctrl: Mult=%b Div=%b want 0/0", name, MultCtrl, DivCtrl);
        end
        checks++;
        if ({HIOut, LOOut} !== want) begin
          errors++;
          $display("FAIL %s result: HI/LO=%h/%h want %h/%h", name, HIOut, LOOut,
                   want[63:32], want[31:0]);
        end
      end else begin
        checks++;
        if (sc !== 1'b1 || oc !== 1'b0 || Busy !== 1'b1 || Timeout !== 1'b0) begin
          errors++;
          $display("FAIL %s wait: selCtrl=%b otherCtrl=%b Busy=%b Timeout=%b want 1/0/1/0",
                   name, sc, oc, Busy, Timeout);
        end
      end
    end
    OpStart = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s opdone_wait: no OpDone within 300 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout});
    end
    checks++;
    if (HIOut !== 32'd0 || LOOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", HIOut, LOOut);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mult_7_m3");
    @(negedge clock);
    checks++;
    if (OpDone !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_single_pulse: OpDone=%b Busy=%b want 0/0", OpDone, Busy);
    end
  endtask

  task automatic test_div();
    run_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, "div_100_7");
  endtask

  task automatic test_div_zero();
    // Preload HI=0x1234 (remainder), LO=0x5678 (quotient).
    run_op(1'b1, 32'h0ACF_1234, 32'h0000_2000, {32'h1234, 32'h5678}, 1'b0, "div_preload");
    @(negedge clock);
    OpStart   = 1'b1;
    OpSel     = 1'b1;
    DivisorIn = 32'd0;
    @(negedge clock);
    OpStart = 1'b0;
    checks++;
    if (DivZero !== 1'b1 || Busy !== 1'b0 || DivCtrl !== 1'b0) begin
      errors++;
      $display("FAIL divzero_pulse: DivZero=%b Busy=%b DivCtrl=%b want 1/0/0",
               DivZero, Busy, DivCtrl);
    end
    @(negedge clock);
    checks++;
    if (DivZero !== 1'b0 || Busy !== 1'b0 || DivCtrl !== 1'b0) begin
      errors++;
      $display("FAIL divzero_after: DivZero=%b Busy=%b DivCtrl=%b want 0/0/0",
               DivZero, Busy, DivCtrl);
    end
    checks++;
    if (HIOut !== 32'h1234 || LOOut !== 32'h5678) begin
      errors++;
      $display("FAIL divzero_hilo: got %h/%h want 00001234/00005678", HIOut, LOOut);
    end
  endtask

  task automatic test_stale_done();
    // MultDone is still high from the earlier MULT; the stale bus holds 7*-3.
    run_op(1'b0, 32'h0001_0000, 32'h0003_0000, {32'h3, 32'h0}, 1'b1, "mult_stale_poke");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (Busy !== 1'b0 || DivCtrl !== 1'b0 || MultCtrl !== 1'b0) begin
        errors++;
        $display("FAIL poke_not_queued: Busy=%b DivCtrl=%b MultCtrl=%b want 0/0/0",
                 Busy, DivCtrl, MultCtrl);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        sel;
    for (int k = 0; k < 5; k++) begin
      a   = $urandom;
      b   = 32'($urandom_range(1, 1000));
      sel = k[0];
      if (!sel) b = $urandom;
      run_op(sel, a, b, sel ? ref_div(a, b) : ref_mul(a, b), 1'b0, "b2b_rand");
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clock);
    lat       = 40;
    op_a      = 32'd9;
    op_b      = 32'd9;
    OpStart   = 1'b1;
    OpSel     = 1'b0;
    DivisorIn = 32'd9;
    @(negedge clock);
    OpStart = 1'b0;
    repeat (RstWait) @(negedge clock);
    checks++;
    if (MultCtrl !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: MultCtrl=%b Busy=%b want 1/1", MultCtrl, Busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout} !== 6'b0) begin
      errors++;
      $display("FAIL rst_wait_flags: got %b want 000000",
               {MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout});
    end
    checks++;
    if (HIOut !== 32'd0 || LOOut !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait_hilo: got %h/%h want 0/0", HIOut, LOOut);
    end
    reset = 1'b0;
    lat   = 5;
    run_op(1'b0, 32'd2, 32'd3, 64'd6, 1'b0, "mult_2x3_after_reset");
  endtask

`ifdef MULDIV_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] before;
    @(negedge clock);
    before    = {HIOut, LOOut};
    stub      = 1'b1;
    op_a      = 32'd5;
    op_b      = 32'd6;
    OpStart   = 1'b1;
    OpSel     = 1'b0;
    DivisorIn = 32'd6;
    @(negedge clock);
    OpStart = 1'b0;
    for (int k = 1; k <= TimeoutCycles; k++) begin
      @(negedge clock);
      checks++;
      if (MultCtrl !== 1'b1 || Timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d]: MultCtrl=%b Timeout=%b want 1/0", k, MultCtrl, Timeout);
      end
    end
    @(negedge clock);
    checks++;
    if (Timeout !== 1'b1 || MultCtrl !== 1'b0 || Busy !== 1'b0 || OpDone !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: Timeout=%b MultCtrl=%b Busy=%b OpDone=%b want 1/0/0/0",
               Timeout, MultCtrl, Busy, OpDone);
    end
    checks++;
    if ({HIOut, LOOut} !== before) begin
      errors++;
      $display("FAIL to_hilo: got %h/%h want %h/%h", HIOut, LOOut,
               before[63:32], before[31:0]);
    end
    @(negedge clock);
    checks++;
    if (Timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_single: Timeout=%b want 0", Timeout);
    end
    stub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stale_done();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MULDIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, WAIT-state cycle limit before abort (used only with MULDIV_TIMEOUT_EN).
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 OpStart  in  1  one-cycle request from the main control FSM, sampled only in IDLE.
REQ-005 OpSel  in  1  0 = MULT, 1 = DIV, sampled with OpStart.
REQ-006 DivisorIn  in  32  divisor operand (RegB value), checked for zero at request.
REQ-007 MultDone / DivDone  in  1  done flags from the iterative multiplier and divider.
REQ-008 MultHIIn, MultLOIn, DivHIIn, DivLOIn  in  32 each  unit result buses.
REQ-009 MultCtrl / DivCtrl  out  1  level enables to the multiplier and divider, held high for the whole operation.
REQ-010 HIOut / LOOut  out  32  architectural HI/LO registers.
REQ-011 Busy  out  1  high in every state except IDLE (stall to the main control FSM).
REQ-012 OpDone  out  1  one-cycle pulse when HI/LO have been updated.
REQ-013 DivZero  out  1  one-cycle pulse on a DIV request with DivisorIn == 0.
REQ-014 Timeout  out  1  one-cycle pulse on a watchdog abort.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, DONE; encoding is free.
REQ-016 IDLE, OpStart=1, and not (OpSel=1 with DivisorIn==0): latch OpSel, go to ISSUE, assert the selected Ctrl from the next cycle.
REQ-017 IDLE, OpStart=1, OpSel=1, DivisorIn==0: DivZero=1 next cycle, stay IDLE, DivCtrl never asserted, HI/LO unchanged.
REQ-018 ISSUE lasts exactly one cycle with the selected Ctrl high; the Done input SHALL be ignored in ISSUE, because the units hold a stale Done until they re-initialise.
REQ-019 WAIT holds the selected Ctrl high; the other Ctrl stays 0; on selected Done=1, load HIOut/LOOut from that unit's HI/LO buses at that edge and go to DONE.
REQ-020 DONE lasts one cycle with both Ctrl low and OpDone=1, then goes to IDLE; dropping Ctrl prevents the unit from restarting.
REQ-021 MULT result mapping: HIOut = MultHIIn, LOOut = MultLOIn (signed 64-bit product).
REQ-022 DIV result mapping: HIOut = DivHIIn (remainder), LOOut = DivLOIn (quotient).
REQ-023 OpStart while Busy=1 SHALL be ignored (not queued).
REQ-024 MultCtrl and DivCtrl SHALL never be high in the same cycle.
REQ-025 HIOut/LOOut change only on the WAIT to DONE edge or on reset.
REQ-026 Latency: Busy rises one cycle after OpStart; OpDone is high the cycle after Done is sampled in WAIT; the next OpStart is accepted the cycle after OpDone.

Reset
REQ-027 Reset SHALL take priority over all inputs, including mid-operation.
REQ-028 On reset, state returns to IDLE and all outputs return to 0: MultCtrl, DivCtrl, HIOut, LOOut, Busy, OpDone, DivZero, Timeout and the watchdog counter.
REQ-029 A reset during WAIT SHALL drop Ctrl in the following cycle; the aborted result is discarded.

Configuration
REQ-030 Macro MULDIV_TIMEOUT_EN. When defined, a counter clears on entry to WAIT and increments each WAIT cycle; on reaching TIMEOUT_CYCLES without Done, the block drops Ctrl, pulses Timeout for one cycle, returns to IDLE and leaves HI/LO unchanged.
REQ-031 When MULDIV_TIMEOUT_EN is undefined, WAIT waits indefinitely, Timeout is tied to 0 and no counter exists.

Verification
REQ-032 MULT, A=7, B=-3 (0xFFFFFFFD), with a real multiplier -> HIOut=0xFFFFFFFF, LOOut=0xFFFFFFEB, single OpDone pulse, MultCtrl low in the DONE cycle.
REQ-033 DIV, 100/7 -> LOOut=14, HIOut=2; DivCtrl high from ISSUE through WAIT; MultCtrl stays 0.
REQ-034 DIV with DivisorIn=0 and HI/LO preloaded 0x1234/0x5678 -> DivZero pulse, Busy stays 0, HI/LO unchanged.
REQ-035 Stale MultDone=1 held during ISSUE -> no transition to DONE until Done is seen in WAIT; OpStart pulsed during WAIT -> ignored.
REQ-036 Reset asserted 10 cycles into WAIT -> all outputs 0 the next cycle; a following MULT 2*3 gives LOOut=6.
REQ-037 With MULDIV_TIMEOUT_EN and TIMEOUT_CYCLES=8, Done stubbed to 0 -> Timeout pulses after 8 WAIT cycles, Ctrl drops, HI/LO unchanged.
